// File: rtl/ram_arbiter2_pkg.sv
// ram_arbiter2_pkg
// Shared definitions for the two-port RAM arbiter: the sequencer state
// encoding, the requester identifiers and the default RAM geometry.
// No ports (package).
package ram_arbiter2_pkg;

    // Geometry of the ram16words array the arbiter fronts.
    localparam int RAM_DW = 4;
    localparam int RAM_AW = 4;

    // Access sequencer states, fixed 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    // Requester identifiers, also used as the round-robin history bit.
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/ram16words.sv
// ram16words
// 16-word single-port RAM with a synchronous write and a combinational read.
// Contents are never cleared by reset.
// Ports:
//   clk        - clock; writes occur on posedge when we=1
//   we         - write enable
//   address    - word address (read and write)
//   write_data - data written at the clock edge
//   read_data  - contents of the addressed word (combinational)
module ram16words #(
    parameter int DW = 4,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] address,
    input  logic [DW-1:0] write_data,
    output logic [DW-1:0] read_data
);

    logic [DW-1:0] mem [2**AW];

    // Storage array; no reset so contents survive an arbiter reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[address] <= write_data;
        end
    end

    assign read_data = mem[address];

endmodule

// File: rtl/ram_arbiter2.sv
// ram_arbiter2
// Round-robin arbiter and access sequencer that serialises single-word
// read/write transactions from two requesters onto one ram16words port.
// Each transaction runs IDLE (grant) -> ACCESS (write strobe) -> CAPTURE
// (read data latched, ack pulsed) and returns to IDLE.
// Ports:
//   clk, rst              - clock and synchronous active-high reset
//   a_req/a_we/a_addr/    - port A request, direction, address, write data
//   a_wdata
//   a_ack, a_rdata        - port A one-cycle completion pulse and read data
//   b_*                   - identical set for port B
//   busy                  - high while a transaction is in ACCESS or CAPTURE
module ram_arbiter2
    import ram_arbiter2_pkg::*;
#(
    parameter int DW = RAM_DW,
    parameter int AW = RAM_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic          busy
);

    state_e        state_q;
    logic          last_grant_q;
    logic          grant_id_q;
    logic          txn_we_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] mem_rdata;
    logic          a_ack_q;
    logic          b_ack_q;
    logic [DW-1:0] a_rdata_q;
    logic [DW-1:0] b_rdata_q;
    logic          busy_q;

    logic          a_elig;
    logic          b_elig;
    logic          grant_valid;
    logic          winner;

    // Round-robin select. A requester whose ack is currently high is masked
    // so that it has the ack cycle to drop or change its request. With both
    // eligible, the port that did not win last time is chosen.
    always_comb begin
        a_elig      = a_req & ~a_ack_q;
        b_elig      = b_req & ~b_ack_q;
        grant_valid = a_elig | b_elig;
        if (a_elig && b_elig) begin
            winner = ~last_grant_q;
        end else if (b_elig) begin
            winner = PORT_B;
        end else begin
            winner = PORT_A;
        end
    end

    // Access sequencer with registered outputs. mem_we is a one-cycle strobe
    // so the RAM write lands on the ACCESS edge; the direction is kept in
    // txn_we_q so CAPTURE knows whether to update read data. A write strobe
    // already registered still reaches the RAM on a reset edge, since the
    // RAM itself is not reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= PORT_B;
            grant_id_q   <= PORT_A;
            txn_we_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        grant_id_q   <= winner;
                        last_grant_q <= winner;
                        busy_q       <= 1'b1;
                        state_q      <= ST_ACCESS;
                        if (winner == PORT_A) begin
                            mem_addr_q  <= a_addr;
                            mem_wdata_q <= a_wdata;
                            mem_we_q    <= a_we;
                            txn_we_q    <= a_we;
                        end else begin
                            mem_addr_q  <= b_addr;
                            mem_wdata_q <= b_wdata;
                            mem_we_q    <= b_we;
                            txn_we_q    <= b_we;
                        end
                    end
                end
                ST_ACCESS: begin
                    mem_we_q <= 1'b0;
                    state_q  <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (grant_id_q == PORT_A) begin
                        a_ack_q <= 1'b1;
                        if (!txn_we_q) begin
                            a_rdata_q <= mem_rdata;
                        end
                    end else begin
                        b_ack_q <= 1'b1;
                        if (!txn_we_q) begin
                            b_rdata_q <= mem_rdata;
                        end
                    end
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    ram16words #(
        .DW(DW),
        .AW(AW)
    ) u_ram (
        .clk       (clk),
        .we        (mem_we_q),
        .address   (mem_addr_q),
        .write_data(mem_wdata_q),
        .read_data (mem_rdata)
    );

    assign a_ack   = a_ack_q;
    assign b_ack   = b_ack_q;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;
    assign busy    = busy_q;

endmodule
